// File: rtl/imm_pkg.sv
// imm_pkg: shared format codes, buffer state and entry types for the immediate packer
package imm_pkg;

    localparam logic [1:0] ITY = 2'b00;
    localparam logic [1:0] STY = 2'b01;
    localparam logic [1:0] BTY = 2'b10;
    localparam logic [1:0] JTY = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    // True when v[31:n] are all equal, i.e. v is a sign extension of its low n+1 bits
    function automatic logic fits(input logic [31:0] v, input int n);
        logic signed [31:0] s;
        s = $signed(v) >>> n;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_enc.sv
// imm_enc: scatters an immediate into the I/S/B/J bit positions of a base instruction
module imm_enc
    import imm_pkg::*;
(
    input  logic [31:0] i_imm,
    input  logic [1:0]  i_scr,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr,
    output logic        o_err
);

    // Place immediate bits per format and flag values the format cannot hold
    always_comb begin
        o_instr = i_base;
        o_err   = 1'b0;
        case (i_scr)
            ITY: begin
                o_instr = {i_imm[11:0], i_base[19:0]};
                o_err   = !fits(i_imm, 11);
            end
            STY: begin
                o_instr = {i_imm[11:5], i_base[24:12], i_imm[4:0], i_base[6:0]};
                o_err   = !fits(i_imm, 11);
            end
            BTY: begin
                o_instr = {i_imm[12], i_imm[10:5], i_base[24:12], i_imm[4:1], i_imm[11], i_base[6:0]};
                o_err   = !fits(i_imm, 12) | i_imm[0];
            end
            JTY: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_base[11:0]};
                o_err   = !fits(i_imm, 20) | i_imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// imm_pack: immediate encoder feeding a two-entry valid/ready output buffer with outcome counters
module imm_pack
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IMM,
    input  logic [1:0]       IMMSCR,
    input  logic [31:0]      BASE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      INSTR,
    output logic             ERR,
    output logic [CNT_W-1:0] ENC_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    buf_state_t       r_state;
    entry_t           r_mem [2];
    logic             r_head;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [31:0] w_enc_instr;
    logic        w_enc_err;
    entry_t      w_new;
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_idx;

    imm_enc u_enc (
        .i_imm   (IMM),
        .i_scr   (IMMSCR),
        .i_base  (BASE),
        .o_instr (w_enc_instr),
        .o_err   (w_enc_err)
    );

    assign w_new     = '{instr: w_enc_instr, err: w_enc_err};
    assign w_head    = r_mem[r_head];
    assign IN_READY  = (r_state != FULL) & ~RST;
    assign OUT_VALID = (r_state != EMPTY);
    assign w_push    = IN_VALID & IN_READY;
    assign w_pop     = OUT_VALID & OUT_READY;
    // In ONE the free slot is the one behind the head; otherwise the head slot itself is free
    assign w_wr_idx  = r_head ^ (r_state == ONE);
    assign INSTR     = OUT_VALID ? w_head.instr : '0;
    assign ERR       = OUT_VALID & w_head.err;
    assign ENC_CNT   = r_enc_cnt;
    assign ERR_CNT   = r_err_cnt;

    // Reset-free storage: write the encoded word into the free slot, advance head on pop
    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[w_wr_idx] <= w_new;
        if (w_pop)
            r_head <= ~r_head;
    end

    // Occupancy FSM and saturating delivered/error counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= EMPTY;
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                EMPTY:   r_state <= w_push ? ONE : EMPTY;
                ONE:     r_state <= (w_push & ~w_pop) ? FULL : (w_pop & ~w_push) ? EMPTY : ONE;
                FULL:    r_state <= w_pop ? ONE : FULL;
                default: r_state <= EMPTY;
            endcase
            if (w_pop & ~w_head.err & ~&r_enc_cnt)
                r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            if (w_pop & w_head.err & ~&r_err_cnt)
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

endmodule
